// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock controller.
package clock_pkg;

    localparam int unsigned TIME_W = 6;

    typedef logic [TIME_W-1:0] time_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SET_MIN   = 2'd1,
        ST_SET_SEC   = 2'd2,
        ST_SET_ALARM = 2'd3
    } state_e;

    // Increment a time field, wrapping to zero once it reaches max_v.
    function automatic time_t inc_wrap(input time_t v, input time_t max_v);
        if (v >= max_v) begin
            return '0;
        end
        return v + time_t'(1);
    endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Buttons, datapath time and control outputs of the clock controller.
interface clock_ctrl_if;

    logic                  btn_mode;
    logic                  btn_inc;
    logic                  alarm_en;
    clock_pkg::time_t      cur_seconds;
    clock_pkg::time_t      cur_minutes;
    logic                  run_en;
    logic                  load_en;
    clock_pkg::time_t      load_minutes;
    clock_pkg::time_t      load_seconds;
    clock_pkg::time_t      alarm_minutes;
    logic                  alarm_ring;
    logic [1:0]            mode;

    modport master (
        output btn_mode, btn_inc, alarm_en, cur_seconds, cur_minutes,
        input  run_en, load_en, load_minutes, load_seconds, alarm_minutes,
               alarm_ring, mode
    );

    modport slave (
        input  btn_mode, btn_inc, alarm_en, cur_seconds, cur_minutes,
        output run_en, load_en, load_minutes, load_seconds, alarm_minutes,
               alarm_ring, mode
    );

endinterface

// File: rtl/clock_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise_c
);

    logic prev_q;
    logic prev_d;

    // Next value of the previous-level register.
    always_comb begin
        prev_d = level;
    end

    // Previous-level register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_c = level & ~prev_q;

endmodule

// File: rtl/clock_ctrl.sv
// Mode/set/alarm controller for a minutes:seconds clock datapath.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned MAX_MIN   = 59,
    parameter int unsigned MAX_SEC   = 59,
    parameter int unsigned ALARM_LEN = 10
) (
    input  logic        clk,
    input  logic        reset,
    clock_ctrl_if.slave bus
);

    localparam int unsigned CNT_W     = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
    localparam time_t       MAX_MIN_T = TIME_W'(MAX_MIN);
    localparam time_t       MAX_SEC_T = TIME_W'(MAX_SEC);

    state_e           state_q, state_d;
    time_t            load_min_q, load_min_d;
    time_t            load_sec_q, load_sec_d;
    time_t            alarm_min_q, alarm_min_d;
    logic             load_en_q, load_en_d;
    logic             run_en_q, run_en_d;
    logic             ring_q, ring_d;
    logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic             match_prev_q, match_prev_d;

    logic             mode_ev_c;
    logic             inc_ev_c;
    logic             match_c;
    logic             cancel_c;

    btn_edge u_mode_edge (.clk(clk), .reset(reset), .level(bus.btn_mode), .rise_c(mode_ev_c));
    btn_edge u_inc_edge  (.clk(clk), .reset(reset), .level(bus.btn_inc),  .rise_c(inc_ev_c));

    assign match_c = bus.alarm_en && (bus.cur_minutes == alarm_min_q) && (bus.cur_seconds == '0);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            load_min_q   <= '0;
            load_sec_q   <= '0;
            alarm_min_q  <= '0;
            load_en_q    <= 1'b0;
            run_en_q     <= 1'b1;
            ring_q       <= 1'b0;
            ring_cnt_q   <= '0;
            match_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_min_q   <= load_min_d;
            load_sec_q   <= load_sec_d;
            alarm_min_q  <= alarm_min_d;
            load_en_q    <= load_en_d;
            run_en_q     <= run_en_d;
            ring_q       <= ring_d;
            ring_cnt_q   <= ring_cnt_d;
            match_prev_q <= match_prev_d;
        end
    end

    // Each mode event steps RUN -> SET_MIN -> SET_SEC -> SET_ALARM -> RUN.
    always_comb begin
        state_d = state_q;
        if (mode_ev_c) begin
            case (state_q)
                ST_RUN:       state_d = ST_SET_MIN;
                ST_SET_MIN:   state_d = ST_SET_SEC;
                ST_SET_SEC:   state_d = ST_SET_ALARM;
                ST_SET_ALARM: state_d = ST_RUN;
                default:      state_d = ST_RUN;
            endcase
        end
    end

    // Field edits, load strobe, run enable and alarm ring timing.
    always_comb begin
        load_min_d   = load_min_q;
        load_sec_d   = load_sec_q;
        alarm_min_d  = alarm_min_q;
        load_en_d    = 1'b0;
        run_en_d     = (state_d == ST_RUN) || (state_d == ST_SET_ALARM);
        ring_d       = ring_q;
        ring_cnt_d   = ring_cnt_q;
        match_prev_d = match_c;
        cancel_c     = mode_ev_c || inc_ev_c || !bus.alarm_en || (state_d != ST_RUN);

        // A mode event takes priority and swallows a coincident inc event.
        case (state_q)
            ST_RUN: begin
                if (mode_ev_c) begin
                    load_min_d = bus.cur_minutes;
                    load_sec_d = bus.cur_seconds;
                end
            end
            ST_SET_MIN: begin
                if (inc_ev_c && !mode_ev_c) begin
                    load_min_d = inc_wrap(load_min_q, MAX_MIN_T);
                end
            end
            ST_SET_SEC: begin
                if (mode_ev_c) begin
                    load_en_d = 1'b1;
                end else if (inc_ev_c) begin
                    load_sec_d = inc_wrap(load_sec_q, MAX_SEC_T);
                end
            end
            ST_SET_ALARM: begin
                if (inc_ev_c && !mode_ev_c) begin
                    alarm_min_d = inc_wrap(alarm_min_q, MAX_MIN_T);
                end
            end
            default: ;
        endcase

        // Ring starts on the first matching cycle and counts down ALARM_LEN cycles.
        if (cancel_c) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
        end else if (ring_q) begin
            if (ring_cnt_q == '0) begin
                ring_d = 1'b0;
            end else begin
                ring_cnt_d = ring_cnt_q - CNT_W'(1);
            end
        end else if ((state_q == ST_RUN) && match_c && !match_prev_q) begin
            ring_d     = 1'b1;
            ring_cnt_d = CNT_W'(ALARM_LEN - 1);
        end
    end

    assign bus.run_en        = run_en_q;
    assign bus.load_en       = load_en_q;
    assign bus.load_minutes  = load_min_q;
    assign bus.load_seconds  = load_sec_q;
    assign bus.alarm_minutes = alarm_min_q;
    assign bus.alarm_ring    = ring_q;
    assign bus.mode          = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed self-checking bench for clock_ctrl.
module tb_clock_ctrl;

    logic clk;
    logic reset;
    int   errors      = 0;
    int   checks      = 0;
    int   load_pulses = 0;
    int   pulses0     = 0;
    int   ring_cycles = 0;

    clock_ctrl_if bus ();

    clock_ctrl #(.MAX_MIN(59), .MAX_SEC(59), .ALARM_LEN(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which the load strobe is high.
    always @(negedge clk) begin
        if (bus.load_en === 1'b1) load_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Button high across one edge, then released; caller advances the release edge.
    task automatic press_mode();
        bus.btn_mode = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
    endtask

    task automatic press_inc();
        bus.btn_inc = 1'b1;
        tick();
        bus.btn_inc = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.btn_mode    = 1'b0;
        bus.btn_inc     = 1'b0;
        bus.alarm_en    = 1'b0;
        bus.cur_minutes = '0;
        bus.cur_seconds = '0;
        reset           = 1'b1;
        tick();
        tick();

        check("rst_mode",      32'(bus.mode), 0);
        check("rst_run_en",    32'(bus.run_en), 1);
        check("rst_load_en",   32'(bus.load_en), 0);
        check("rst_load_min",  32'(bus.load_minutes), 0);
        check("rst_load_sec",  32'(bus.load_seconds), 0);
        check("rst_alarm_min", 32'(bus.alarm_minutes), 0);
        check("rst_ring",      32'(bus.alarm_ring), 0);
        reset = 1'b0;
        tick();

        // Set sequence from 12:34: +3 minutes, +2 seconds.
        bus.cur_minutes = 6'd12;
        bus.cur_seconds = 6'd34;
        press_mode();
        check("set_mode_min",  32'(bus.mode), 1);
        check("set_run_min",   32'(bus.run_en), 0);
        check("set_cap_min",   32'(bus.load_minutes), 12);
        check("set_cap_sec",   32'(bus.load_seconds), 34);
        tick();
        for (int i = 0; i < 3; i++) begin
            press_inc();
            tick();
        end
        check("set_min_15",    32'(bus.load_minutes), 15);
        press_mode();
        check("set_mode_sec",  32'(bus.mode), 2);
        check("set_run_sec",   32'(bus.run_en), 0);
        check("set_no_load",   32'(bus.load_en), 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            press_inc();
            tick();
        end
        check("set_sec_36",    32'(bus.load_seconds), 36);
        pulses0 = load_pulses;
        press_mode();
        check("set_mode_alm",  32'(bus.mode), 3);
        check("set_run_alm",   32'(bus.run_en), 1);
        check("set_load_en",   32'(bus.load_en), 1);
        check("set_load_min",  32'(bus.load_minutes), 15);
        check("set_load_sec",  32'(bus.load_seconds), 36);
        tick();
        check("set_load_drop", 32'(bus.load_en), 0);
        tick();
        tick();
        check("set_one_pulse", 32'(load_pulses - pulses0), 1);
        for (int i = 0; i < 5; i++) begin
            press_inc();
            tick();
        end
        check("alm_min_5",     32'(bus.alarm_minutes), 5);
        press_mode();
        check("back_run",      32'(bus.mode), 0);
        check("back_run_en",   32'(bus.run_en), 1);
        tick();

        // Minute wrap and held button.
        bus.cur_minutes = 6'd58;
        bus.cur_seconds = 6'd0;
        press_mode();
        check("wrap_cap",      32'(bus.load_minutes), 58);
        tick();
        for (int i = 0; i < 2; i++) begin
            press_inc();
            tick();
        end
        check("wrap_zero",     32'(bus.load_minutes), 0);
        bus.btn_inc = 1'b1;
        repeat (20) tick();
        bus.btn_inc = 1'b0;
        tick();
        check("held_once",     32'(bus.load_minutes), 1);
        for (int i = 0; i < 3; i++) begin
            press_mode();
            tick();
        end
        check("wrap_run",      32'(bus.mode), 0);
        check("wrap_alm_keep", 32'(bus.alarm_minutes), 5);

        // Alarm at 05:00 held for 15 cycles.
        bus.cur_minutes = 6'd5;
        bus.cur_seconds = 6'd0;
        bus.alarm_en    = 1'b1;
        ring_cycles     = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.alarm_ring === 1'b1) ring_cycles++;
        end
        check("ring_len",      32'(ring_cycles), 10);
        check("ring_no_retrg", 32'(bus.alarm_ring), 0);

        // Cancel by inc while ringing.
        bus.cur_seconds = 6'd1;
        tick();
        bus.cur_seconds = 6'd0;
        tick();
        check("ring_start",    32'(bus.alarm_ring), 1);
        tick();
        tick();
        press_inc();
        check("ring_cancel",   32'(bus.alarm_ring), 0);
        check("run_inc_ign",   32'(bus.load_minutes), 1);
        repeat (5) tick();
        check("cancel_hold",   32'(bus.alarm_ring), 0);

        // Mode and inc in the same cycle.
        bus.cur_seconds = 6'd1;
        tick();
        press_mode();
        check("prio_mode1",    32'(bus.mode), 1);
        check("prio_cap_min",  32'(bus.load_minutes), 5);
        tick();
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        check("prio_mode2",    32'(bus.mode), 2);
        check("prio_min_keep", 32'(bus.load_minutes), 5);
        tick();
        check("prio_sec_keep", 32'(bus.load_seconds), 1);

        // Reset while in SET_SEC abandons the edit.
        pulses0 = load_pulses;
        press_inc();
        check("rs_sec_inc",    32'(bus.load_seconds), 2);
        tick();
        reset = 1'b1;
        tick();
        check("rs_mode",       32'(bus.mode), 0);
        check("rs_run_en",     32'(bus.run_en), 1);
        check("rs_load_en",    32'(bus.load_en), 0);
        check("rs_load_sec",   32'(bus.load_seconds), 0);
        reset = 1'b0;
        repeat (5) tick();
        check("rs_no_pulse",   32'(load_pulses - pulses0), 0);
        check("rs_still_run",  32'(bus.mode), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
